// File: rtl/pc_update_unit.sv
// Program-counter update unit for the multicycle MIPS datapath.
// Owns the PC register, qualifies PCEn and keeps a taken-branch counter.
module pc_update_unit #(
    parameter int                  WIDTH        = 32,
    parameter logic [WIDTH-1:0]    RESET_VECTOR = 32'h0040_0000,
    parameter int                  CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pc_write,
    input  logic                 branch_eq,
    input  logic                 branch_ne,
    input  logic                 zero,
    input  logic [1:0]           pc_source,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic [25:0]          jump_index,
    input  logic [WIDTH-1:0]     reg_target,
    input  logic                 err_clear,
    output logic [WIDTH-1:0]     pc_out,
    output logic                 pc_en_out,
    output logic                 branch_taken,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic                 misalign_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0] next_pc;
    logic             aligned;

    always_comb begin
        branch_taken = ~stall & ((branch_eq & zero) | (branch_ne & ~zero));
        pc_en_out    = ~stall & (pc_write | branch_taken);
    end

    always_comb begin
        next_pc = alu_result;
        unique case (pc_source)
            2'b00: next_pc = alu_result;
            2'b01: next_pc = alu_out;
            2'b10: next_pc = {pc_out[WIDTH-1:28], jump_index, 2'b00};
            2'b11: next_pc = reg_target;
        endcase
    end

    assign aligned = (next_pc[1:0] == 2'b00);

    // A misaligned target must not reach the PC; the fault is latched instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out       <= RESET_VECTOR;
            taken_count  <= '0;
            misalign_err <= 1'b0;
        end else if (!stall) begin
            if (pc_en_out && aligned) begin
                pc_out <= next_pc;
            end
            if (pc_en_out && !aligned) begin
                misalign_err <= 1'b1;
            end else if (err_clear) begin
                misalign_err <= 1'b0;
            end
            if (branch_taken && taken_count != CNT_MAX) begin
                taken_count <= taken_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit against a behavioural model.
// A second instance with a 2-bit counter exercises saturation.
module tb_pc_update_unit;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        pc_write = 1'b0;
    logic        branch_eq = 1'b0;
    logic        branch_ne = 1'b0;
    logic        zero = 1'b0;
    logic        err_clear = 1'b0;
    logic [1:0]  pc_source = 2'b00;
    logic [31:0] alu_result = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] reg_target = '0;
    logic [25:0] jump_index = '0;

    logic [31:0] pc_out;
    logic        pc_en_out;
    logic        branch_taken;
    logic [15:0] taken_count;
    logic        misalign_err;

    logic [31:0] pc_out2;
    logic        pc_en_out2;
    logic        branch_taken2;
    logic [1:0]  taken_count2;
    logic        misalign_err2;

    int passed = 0;
    int total = 0;

    logic [31:0] m_pc;
    int          m_cnt;
    int          m_cnt2;
    bit          m_err;

    pc_update_unit #(.WIDTH(32), .RESET_VECTOR(RV), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_write(pc_write),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
        .pc_source(pc_source), .alu_result(alu_result), .alu_out(alu_out),
        .jump_index(jump_index), .reg_target(reg_target),
        .err_clear(err_clear), .pc_out(pc_out), .pc_en_out(pc_en_out),
        .branch_taken(branch_taken), .taken_count(taken_count),
        .misalign_err(misalign_err)
    );

    pc_update_unit #(.WIDTH(32), .RESET_VECTOR(RV), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .pc_write(pc_write),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
        .pc_source(pc_source), .alu_result(alu_result), .alu_out(alu_out),
        .jump_index(jump_index), .reg_target(reg_target),
        .err_clear(err_clear), .pc_out(pc_out2), .pc_en_out(pc_en_out2),
        .branch_taken(branch_taken2), .taken_count(taken_count2),
        .misalign_err(misalign_err2)
    );

    always #5 clk = ~clk;

    function automatic bit exp_taken();
        if (stall) return 1'b0;
        return (branch_eq && zero) || (branch_ne && !zero);
    endfunction

    function automatic bit exp_en();
        return !stall && (pc_write || exp_taken());
    endfunction

    function automatic logic [31:0] exp_target();
        case (pc_source)
            2'd0: return alu_result;
            2'd1: return alu_out;
            2'd2: return (m_pc & 32'hF000_0000) + 32'(jump_index) * 4;
            default: return reg_target;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RV;
        m_cnt = 0;
        m_cnt2 = 0;
        m_err = 1'b0;
    endtask

    task automatic idle();
        stall = 0; pc_write = 0; branch_eq = 0; branch_ne = 0;
        zero = 0; err_clear = 0; pc_source = 2'd0;
    endtask

    // Advance one clock and let the model take the same step.
    task automatic tick();
        bit          t;
        bit          en;
        logic [31:0] nx;
        t = exp_taken();
        en = exp_en();
        nx = exp_target();
        @(posedge clk);
        #1;
        if (!stall) begin
            if (en && (nx % 4) != 0) m_err = 1'b1;
            else if (err_clear) m_err = 1'b0;
            if (en && (nx % 4) == 0) m_pc = nx;
            if (t) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic apply_reset();
        idle();
        reset = 0;
        #3;
        reset = 1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        model_reset();
        #12;
        total++; if (pc_out !== RV) $display("FAIL reset_pc got %h want %h", pc_out, RV); else passed++;
        total++; if (taken_count !== 16'd0) $display("FAIL reset_cnt got %0d want 0", taken_count); else passed++;
        total++; if (misalign_err !== 1'b0) $display("FAIL reset_err got %b want 0", misalign_err); else passed++;
        reset = 1;
        @(posedge clk); #1;
        pc_write = 1; pc_source = 2'd3; reg_target = 32'h0040_0010; zero = 1; branch_eq = 1;
        tick();
        idle();
        total++; if (pc_out !== 32'h0040_0010) $display("FAIL pre_reset_pc got %h want 00400010", pc_out); else passed++;
        reset = 0;
        #1;
        total++; if (pc_out !== RV) $display("FAIL async_reset_pc got %h want %h", pc_out, RV); else passed++;
        total++; if (taken_count !== 16'd0) $display("FAIL async_reset_cnt got %0d want 0", taken_count); else passed++;
        reset = 1;
        model_reset();
        #1;
    endtask

    task automatic test_fetch();
        apply_reset();
        pc_write = 1; pc_source = 2'd0; alu_result = 32'h0040_0004;
        #1;
        total++; if (pc_en_out !== 1'b1) $display("FAIL fetch_en got %b want 1", pc_en_out); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL fetch_taken got %b want 0", branch_taken); else passed++;
        tick();
        idle();
        total++; if (pc_out !== 32'h0040_0004) $display("FAIL fetch_pc got %h want 00400004", pc_out); else passed++;
    endtask

    task automatic test_branch();
        apply_reset();
        branch_eq = 1; zero = 1; pc_source = 2'd1; alu_out = 32'h0040_0040;
        #1;
        total++; if (branch_taken !== 1'b1) $display("FAIL beq_taken got %b want 1", branch_taken); else passed++;
        tick();
        total++; if (pc_out !== 32'h0040_0040) $display("FAIL beq_pc got %h want 00400040", pc_out); else passed++;
        total++; if (taken_count !== 16'd1) $display("FAIL beq_cnt got %0d want 1", taken_count); else passed++;
        zero = 0; alu_out = 32'h0040_0080;
        #1;
        total++; if (pc_en_out !== 1'b0) $display("FAIL beq_nt_en got %b want 0", pc_en_out); else passed++;
        tick();
        total++; if (pc_out !== 32'h0040_0040) $display("FAIL beq_nt_pc got %h want 00400040", pc_out); else passed++;
        total++; if (taken_count !== 16'd1) $display("FAIL beq_nt_cnt got %0d want 1", taken_count); else passed++;
        branch_eq = 0; branch_ne = 1; zero = 0;
        tick();
        idle();
        total++; if (pc_out !== 32'h0040_0080) $display("FAIL bne_pc got %h want 00400080", pc_out); else passed++;
        total++; if (taken_count !== 16'd2) $display("FAIL bne_cnt got %0d want 2", taken_count); else passed++;
        pc_write = 1;
        tick();
        idle();
        total++; if (taken_count !== 16'd2) $display("FAIL pcw_cnt got %0d want 2", taken_count); else passed++;
    endtask

    task automatic test_jump();
        apply_reset();
        pc_write = 1; pc_source = 2'd3; reg_target = 32'h1040_0000;
        tick();
        pc_source = 2'd2; jump_index = 26'h0000123;
        tick();
        total++; if (pc_out !== 32'h1000_048C) $display("FAIL jump_pc got %h want 1000048c", pc_out); else passed++;
        pc_source = 2'd3; reg_target = 32'h0040_0100;
        tick();
        idle();
        total++; if (pc_out !== 32'h0040_0100) $display("FAIL jr_pc got %h want 00400100", pc_out); else passed++;
    endtask

    task automatic test_misalign();
        apply_reset();
        pc_write = 1; pc_source = 2'd3; reg_target = 32'h0040_0102;
        tick();
        idle();
        total++; if (pc_out !== RV) $display("FAIL mis_pc got %h want %h", pc_out, RV); else passed++;
        total++; if (misalign_err !== 1'b1) $display("FAIL mis_err got %b want 1", misalign_err); else passed++;
        tick();
        total++; if (misalign_err !== 1'b1) $display("FAIL mis_sticky got %b want 1", misalign_err); else passed++;
        err_clear = 1;
        tick();
        idle();
        total++; if (misalign_err !== 1'b0) $display("FAIL mis_clear got %b want 0", misalign_err); else passed++;
        pc_write = 1; pc_source = 2'd3; reg_target = 32'h0040_0101; err_clear = 1;
        tick();
        idle();
        total++; if (misalign_err !== 1'b1) $display("FAIL mis_setwins got %b want 1", misalign_err); else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] pc0;
        int          c0;
        apply_reset();
        pc_write = 1; pc_source = 2'd0; alu_result = 32'h0040_0004;
        tick();
        pc0 = pc_out;
        c0 = int'(taken_count);
        stall = 1; pc_write = 1; branch_eq = 1; zero = 1;
        pc_source = 2'd0; alu_result = 32'h0040_0200; err_clear = 1;
        #1;
        total++; if (pc_en_out !== 1'b0) $display("FAIL stall_en got %b want 0", pc_en_out); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL stall_taken got %b want 0", branch_taken); else passed++;
        tick();
        tick();
        idle();
        total++; if (pc_out !== pc0) $display("FAIL stall_pc got %h want %h", pc_out, pc0); else passed++;
        total++; if (int'(taken_count) != c0) $display("FAIL stall_cnt got %0d want %0d", taken_count, c0); else passed++;
    endtask

    task automatic test_saturation();
        apply_reset();
        branch_eq = 1; branch_ne = 1; zero = 0; pc_source = 2'd0; alu_result = 32'h0040_0020;
        for (int i = 0; i < 5; i++) tick();
        idle();
        total++; if (taken_count2 !== 2'd3) $display("FAIL sat_cnt2 got %0d want 3", taken_count2); else passed++;
        total++; if (taken_count !== 16'd5) $display("FAIL sat_cnt got %0d want 5", taken_count); else passed++;
    endtask

    task automatic test_random();
        int errs;
        apply_reset();
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            pc_write = $urandom_range(0, 1) == 1;
            branch_eq = $urandom_range(0, 2) == 0;
            branch_ne = $urandom_range(0, 2) == 0;
            zero = $urandom_range(0, 1) == 1;
            err_clear = $urandom_range(0, 5) == 0;
            pc_source = 2'($urandom_range(0, 3));
            alu_result = $urandom & ~(($urandom_range(0, 7) == 0) ? 32'h0 : 32'h3);
            alu_out = $urandom & ~(($urandom_range(0, 7) == 0) ? 32'h0 : 32'h3);
            reg_target = $urandom & ~(($urandom_range(0, 7) == 0) ? 32'h0 : 32'h3);
            jump_index = 26'($urandom);
            #1;
            total++;
            if (branch_taken !== exp_taken() || pc_en_out !== exp_en()) begin
                errs++;
                $display("FAIL rnd_comb[%0d] got %b/%b want %b/%b", i, branch_taken, pc_en_out, exp_taken(), exp_en());
            end else passed++;
            tick();
            total++;
            if (pc_out !== m_pc || int'(taken_count) != m_cnt ||
                misalign_err !== m_err || int'(taken_count2) != m_cnt2) begin
                errs++;
                $display("FAIL rnd_state[%0d] got %h/%0d/%b/%0d want %h/%0d/%b/%0d",
                         i, pc_out, taken_count, misalign_err, taken_count2,
                         m_pc, m_cnt, m_err, m_cnt2);
            end else passed++;
            if (errs > 10) break;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_misalign();
        test_stall();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
